axi4_apb_bridge: RTL and testbench

AXI4_APB_BRIDGE -- requirements
Module: axi4_apb_bridge

---
 rtl/axi4_apb_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi4_apb_bridge.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_apb_bridge.sv
// rtl/axi4_apb_bridge.sv - AXI4 slave to APB bridge, one outstanding transaction
package types_amba_pkg;
    localparam int CFG_SYSBUS_ADDR_BITS = 48;
    localparam int CFG_SYSBUS_ID_BITS   = 5;
    localparam int CFG_SYSBUS_USER_BITS = 1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic [2:0]                      prot;
    } axi4_metadata_type;

    typedef struct packed {
        logic                            aw_valid;
        axi4_metadata_type               aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]   aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] aw_user;
        logic                            w_valid;
        logic [63:0]                     w_data;
        logic                            w_last;
        logic [7:0]                      w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0] w_user;
        logic                            b_ready;
        logic                            ar_valid;
        axi4_metadata_type               ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]   ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] ar_user;
        logic                            r_ready;
    } axi4_slave_in_type;

    typedef struct packed {
        logic                            aw_ready;
        logic                            w_ready;
        logic                            b_valid;
        logic [1:0]                      b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]   b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] b_user;
        logic                            ar_ready;
        logic                            r_valid;
        logic [1:0]                      r_resp;
        logic [63:0]                     r_data;
        logic                            r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]   r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] r_user;
    } axi4_slave_out_type;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;

    localparam axi4_slave_out_type axi4_slave_out_none = '0;
    localparam apb_in_type         apb_in_none         = '0;

    function automatic logic [31:0] XSizeToBytes(input logic [2:0] size);
        return 32'd1 << size;
    endfunction
endpackage

module axi4_apb_bridge
    import types_amba_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_nrst,
    input  axi4_slave_in_type  i_xslvi,
    output axi4_slave_out_type o_xslvo,
    output apb_in_type         o_apbi,
    input  apb_out_type        i_apbo
);
    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, RRESP, BRESP} state_t;

    state_t                          state;
    logic [31:0]                     addr;
    logic [7:0]                      beat_cnt;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic [2:0]                      prot;
    logic [CFG_SYSBUS_ID_BITS-1:0]   id;
    logic [CFG_SYSBUS_USER_BITS-1:0] user;
    logic                            is_write;
    logic                            err;
    logic                            half;
    logic                            last_read;
    logic [63:0]                     wdata;
    logic [7:0]                      wstrb;
    logic [63:0]                     rdata;

    logic                            grant_rd;
    logic                            grant_wr;
    axi4_metadata_type               req;
    logic [31:0]                     paddr;
    logic [31:0]                     next_addr;
    logic                            unused_bits;

    // On a tie the channel that did not win last time is served.
    assign grant_rd  = i_xslvi.ar_valid && (!i_xslvi.aw_valid || !last_read);
    assign grant_wr  = i_xslvi.aw_valid && !grant_rd;
    assign req       = grant_rd ? i_xslvi.ar_bits : i_xslvi.aw_bits;
    assign paddr     = {addr[31:2], 2'b00} + {29'd0, half, 2'b00};
    assign next_addr = (burst == AXI_BURST_FIXED) ? addr : addr + XSizeToBytes(size);
    assign unused_bits = ^{req.addr[CFG_SYSBUS_ADDR_BITS-1:32], i_xslvi.w_last, i_xslvi.w_user};

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= IDLE;
            addr      <= '0;
            beat_cnt  <= '0;
            size      <= '0;
            burst     <= '0;
            prot      <= '0;
            id        <= '0;
            user      <= '0;
            is_write  <= 1'b0;
            err       <= 1'b0;
            half      <= 1'b0;
            last_read <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd || grant_wr) begin
                        addr      <= req.addr[31:0];
                        beat_cnt  <= req.len;
                        size      <= (req.size > 3'd3) ? 3'd3 : req.size;
                        burst     <= req.burst;
                        prot      <= req.prot;
                        id        <= grant_rd ? i_xslvi.ar_id : i_xslvi.aw_id;
                        user      <= grant_rd ? i_xslvi.ar_user : i_xslvi.aw_user;
                        is_write  <= grant_wr;
                        err       <= 1'b0;
                        half      <= 1'b0;
                        last_read <= grant_rd;
                        state     <= grant_rd ? SETUP : WDATA;
                    end
                end
                WDATA: begin
                    if (i_xslvi.w_valid) begin
                        wdata <= i_xslvi.w_data;
                        wstrb <= i_xslvi.w_strb;
                        state <= SETUP;
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (i_apbo.pready) begin
                        if (i_apbo.pslverr) begin
                            err <= 1'b1;
                        end
                        if (!is_write) begin
                            if (size != 3'd3) begin
                                rdata <= {i_apbo.prdata, i_apbo.prdata};
                            end else if (half) begin
                                rdata[63:32] <= i_apbo.prdata;
                            end else begin
                                rdata[31:0] <= i_apbo.prdata;
                            end
                        end
                        // 64-bit beats take a second APB transfer for the upper word.
                        if (size == 3'd3 && !half) begin
                            half  <= 1'b1;
                            state <= SETUP;
                        end else begin
                            half <= 1'b0;
                            if (!is_write) begin
                                state <= RRESP;
                            end else if (beat_cnt == 8'd0) begin
                                state <= BRESP;
                            end else begin
                                beat_cnt <= beat_cnt - 8'd1;
                                addr     <= next_addr;
                                state    <= WDATA;
                            end
                        end
                    end
                end
                RRESP: begin
                    if (i_xslvi.r_ready) begin
                        err <= 1'b0;
                        if (beat_cnt == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                            addr     <= next_addr;
                            state    <= SETUP;
                        end
                    end
                end
                BRESP: begin
                    if (i_xslvi.b_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_xslvo          = axi4_slave_out_none;
        o_xslvo.ar_ready = (state == IDLE);
        o_xslvo.aw_ready = (state == IDLE);
        o_xslvo.w_ready  = (state == WDATA);
        o_xslvo.r_valid  = (state == RRESP);
        o_xslvo.r_data   = rdata;
        o_xslvo.r_resp   = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        o_xslvo.r_last   = (state == RRESP) && (beat_cnt == 8'd0);
        o_xslvo.r_id     = id;
        o_xslvo.r_user   = user;
        o_xslvo.b_valid  = (state == BRESP);
        o_xslvo.b_resp   = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        o_xslvo.b_id     = id;
        o_xslvo.b_user   = user;

        o_apbi = apb_in_none;
        if (state == SETUP || state == ACCESS) begin
            o_apbi.pselx   = 1'b1;
            o_apbi.penable = (state == ACCESS);
            o_apbi.paddr   = paddr;
            o_apbi.pprot   = prot;
            o_apbi.pwrite  = is_write;
            o_apbi.pwdata  = paddr[2] ? wdata[63:32] : wdata[31:0];
            o_apbi.pstrb   = paddr[2] ? wstrb[7:4] : wstrb[3:0];
        end
    end
endmodule

// File: tb/tb_axi4_apb_bridge.sv
// tb/tb_axi4_apb_bridge.sv - table, directed and random checks of axi4_apb_bridge
module tb_axi4_apb_bridge;
    import types_amba_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    axi4_slave_in_type  xslvi;
    axi4_slave_out_type xslvo;
    apb_in_type         apbi;
    apb_out_type        apbo;

    always #5 clk = ~clk;

    axi4_apb_bridge dut (
        .i_clk  (clk),
        .i_nrst (rst_n),
        .i_xslvi(xslvi),
        .o_xslvo(xslvo),
        .o_apbi (apbi),
        .i_apbo (apbo)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  prot;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_rec_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          waits;
        int          err;
        int          exp_napb;
        logic [31:0] exp_last_paddr;
        logic [1:0]  exp_resp;
    } vec_t;

    logic [31:0] pmem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];
    bit          err_xfer [int];
    int          apb_wait = 0;
    int          xfer_idx = 0;
    int          proto_bad = 0;
    apb_rec_t    apb_log [$];

    logic [63:0] wq [$];
    logic [7:0]  sq [$];
    logic [63:0] got_data [$];
    logic [1:0]  got_resp [$];
    bit          got_last [$];
    logic [4:0]  got_id;
    logic        got_user;
    logic [1:0]  got_bresp;

    apb_rec_t    exp_apb [$];
    logic [63:0] exp_rdata [$];
    logic [1:0]  exp_rresp [$];
    logic [1:0]  exp_bresp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction
    function automatic logic [31:0] pm_rd(input logic [31:0] a);
        return pmem.exists(a) ? pmem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] mm_rd(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // APB peripheral: fixed wait states, memory, error injection by transfer index, protocol watch.
    initial begin
        int  wc;
        bit  prev_psel;
        logic [31:0] prev_addr;
        wc = 0;
        prev_psel = 0;
        prev_addr = '0;
        apbo = '0;
        forever begin
            @(negedge clk);
            apbo = '0;
            if (apbi.penable && !apbi.pselx) proto_bad++;
            if (apbi.pselx && apbi.penable && (!prev_psel || prev_addr != apbi.paddr)) proto_bad++;
            if (apbi.pselx && apbi.penable) begin
                if (wc >= apb_wait) begin
                    apbo.pready  = 1'b1;
                    apbo.prdata  = pm_rd(apbi.paddr);
                    apbo.pslverr = err_xfer.exists(xfer_idx);
                    apb_log.push_back('{apbi.paddr, apbi.pwrite, apbi.pprot, apbi.pwdata, apbi.pstrb});
                    if (apbi.pwrite) pmem[apbi.paddr] = merge(pm_rd(apbi.paddr), apbi.pwdata, apbi.pstrb);
                    xfer_idx++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
            prev_psel = apbi.pselx;
            prev_addr = apbi.paddr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return xslvo.ar_ready;
            1: return xslvo.aw_ready;
            2: return xslvo.w_ready;
            3: return xslvo.r_valid;
            4: return xslvo.b_valid;
            default: return apbi.penable;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        for (int i = 0; i < 400 && !sig(w); i++) cyc();
        if (!sig(w)) begin
            total++;
            bad++;
            $display("FAIL timeout %s: got 0 expected 1", name);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        pmem[a] = v;
        mmem[a] = v;
    endtask

    task automatic set_req(input bit wr, input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [4:0] id);
        axi4_metadata_type m;
        m.addr  = {16'($urandom), addr};
        m.len   = 8'(len);
        m.size  = size;
        m.burst = burst;
        m.prot  = id[2:0];
        if (wr) begin
            xslvi.aw_bits = m;
            xslvi.aw_id   = id;
            xslvi.aw_user = id[0];
        end else begin
            xslvi.ar_bits = m;
            xslvi.ar_id   = id;
            xslvi.ar_user = id[0];
        end
    endtask

    // Reference: beat addresses, APB word sequence, data and responses from plain arithmetic.
    task automatic model(input bit wr, input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [2:0] prot);
        int sz, nb, x;
        bit any_err;
        sz = (size > 3) ? 3 : int'(size);
        nb = 1 << sz;
        x = 0;
        any_err = 0;
        exp_apb.delete();
        exp_rdata.delete();
        exp_rresp.delete();
        for (int b = 0; b <= len; b++) begin
            logic [31:0] a, w;
            logic [31:0] v [2];
            bit be;
            be = 0;
            v[0] = '0;
            v[1] = '0;
            a = (burst == AXI_BURST_FIXED) ? addr : addr + 32'(b * nb);
            w = {a[31:2], 2'b00};
            for (int h = 0; h < ((sz == 3) ? 2 : 1); h++) begin
                apb_rec_t r;
                r.addr = w + 32'(4 * h);
                r.wr   = wr;
                r.prot = prot;
                if (wr) begin
                    r.wdata = r.addr[2] ? wq[b][63:32] : wq[b][31:0];
                    r.strb  = r.addr[2] ? sq[b][7:4] : sq[b][3:0];
                    mmem[r.addr] = merge(mm_rd(r.addr), r.wdata, r.strb);
                end else begin
                    r.wdata = '0;
                    r.strb  = '0;
                    v[h] = mm_rd(r.addr);
                end
                exp_apb.push_back(r);
                if (err_xfer.exists(x)) be = 1;
                x++;
            end
            if (!wr) begin
                exp_rdata.push_back((sz == 3) ? {v[1], v[0]} : {v[0], v[0]});
                exp_rresp.push_back(be ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
            end
            any_err |= be;
        end
        exp_bresp = any_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endtask

    task automatic do_read(input int len, input int hold);
        got_data.delete();
        got_resp.delete();
        got_last.delete();
        xslvi.ar_valid = 1'b1;
        wait_for(0, "ar_ready");
        cyc();
        xslvi.ar_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wait_for(3, "r_valid");
            if (b == 0) begin
                for (int k = 0; k < hold; k++) begin
                    cyc();
                    chk("r_valid_held", xslvo.r_valid, 1);
                    chk("r_data_held", xslvo.r_data, exp_rdata[0]);
                    chk("no_apb_while_held", apbi.pselx, 0);
                end
            end
            got_data.push_back(xslvo.r_data);
            got_resp.push_back(xslvo.r_resp);
            got_last.push_back(xslvo.r_last);
            got_id   = xslvo.r_id;
            got_user = xslvo.r_user;
            xslvi.r_ready = 1'b1;
            cyc();
            xslvi.r_ready = 1'b0;
        end
    endtask

    task automatic do_write(input int len);
        xslvi.aw_valid = 1'b1;
        wait_for(1, "aw_ready");
        cyc();
        xslvi.aw_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wait_for(2, "w_ready");
            xslvi.w_valid = 1'b1;
            xslvi.w_data  = wq[b];
            xslvi.w_strb  = sq[b];
            xslvi.w_last  = (b == len);
            cyc();
            xslvi.w_valid = 1'b0;
        end
        wait_for(4, "b_valid");
        got_bresp = xslvo.b_resp;
        got_id    = xslvo.b_id;
        got_user  = xslvo.b_user;
        xslvi.b_ready = 1'b1;
        cyc();
        xslvi.b_ready = 1'b0;
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [4:0] id, input int waits,
                           input int err, input int hold);
        int n;
        apb_wait = waits;
        err_xfer.delete();
        if (err >= 0) err_xfer[err] = 1;
        xfer_idx = 0;
        apb_log.delete();
        wq.delete();
        sq.delete();
        for (int b = 0; b <= len; b++) begin
            wq.push_back({$urandom, $urandom});
            sq.push_back(8'($urandom));
        end
        model(wr, addr, len, size, burst, id[2:0]);
        set_req(wr, addr, len, size, burst, id);
        if (wr) do_write(len);
        else do_read(len, hold);
        chk("apb_count", apb_log.size(), exp_apb.size());
        n = (apb_log.size() < exp_apb.size()) ? apb_log.size() : exp_apb.size();
        for (int i = 0; i < n; i++) begin
            chk("paddr", apb_log[i].addr, exp_apb[i].addr);
            chk("pwrite", apb_log[i].wr, exp_apb[i].wr);
            chk("pprot", apb_log[i].prot, exp_apb[i].prot);
            if (wr) begin
                chk("pwdata", apb_log[i].wdata, exp_apb[i].wdata);
                chk("pstrb", apb_log[i].strb, exp_apb[i].strb);
            end
        end
        chk("resp_id", got_id, id);
        chk("resp_user", got_user, id[0]);
        if (wr) begin
            chk("b_resp", got_bresp, exp_bresp);
        end else begin
            chk("beat_count", got_data.size(), len + 1);
            n = (got_data.size() < exp_rdata.size()) ? got_data.size() : exp_rdata.size();
            for (int i = 0; i < n; i++) begin
                chk("r_data", got_data[i], exp_rdata[i]);
                chk("r_resp", got_resp[i], exp_rresp[i]);
                chk("r_last", got_last[i], (i == len));
            end
        end
    endtask

    task automatic tie_test(input int n);
        int rd_left, wr_left;
        bit order [$];
        rd_left = n;
        wr_left = n;
        apb_wait = 0;
        err_xfer.delete();
        set_req(0, 32'h0000_A000, 0, 3'd2, AXI_BURST_INCR, 5'd1);
        set_req(1, 32'h0000_B000, 0, 3'd2, AXI_BURST_INCR, 5'd2);
        xslvi.ar_valid = 1'b1;
        xslvi.aw_valid = 1'b1;
        for (int k = 0; k < 2 * n; k++) begin
            wait_for(0, "ar_ready_tie");
            cyc();
            if (xslvo.w_ready) begin
                order.push_back(1);
                xslvi.aw_valid = 1'b0;
                xslvi.w_valid  = 1'b1;
                xslvi.w_data   = '0;
                xslvi.w_strb   = '0;
                cyc();
                xslvi.w_valid = 1'b0;
                wait_for(4, "b_valid_tie");
                xslvi.b_ready = 1'b1;
                cyc();
                xslvi.b_ready = 1'b0;
                wr_left--;
                xslvi.aw_valid = (wr_left > 0);
            end else begin
                order.push_back(0);
                xslvi.ar_valid = 1'b0;
                wait_for(3, "r_valid_tie");
                xslvi.r_ready = 1'b1;
                cyc();
                xslvi.r_ready = 1'b0;
                rd_left--;
                xslvi.ar_valid = (rd_left > 0);
            end
        end
        xslvi.ar_valid = 1'b0;
        xslvi.aw_valid = 1'b0;
        for (int k = 0; k < order.size(); k++) chk("grant_order", order[k], k % 2);
    endtask

    vec_t vecs [$];

    initial begin
        xslvi = '0;
        vecs.push_back('{0, 32'h0000_1004,   0, 3'd2, AXI_BURST_INCR,  2, -1,   1, 32'h0000_1004, AXI_RESP_OKAY});
        vecs.push_back('{1, 32'h0000_2000,   1, 3'd3, AXI_BURST_INCR,  0, -1,   4, 32'h0000_200C, AXI_RESP_OKAY});
        vecs.push_back('{1, 32'h0000_3000,   3, 3'd2, AXI_BURST_INCR,  1,  1,   4, 32'h0000_300C, AXI_RESP_SLVERR});
        vecs.push_back('{0, 32'h0000_4000,   2, 3'd2, AXI_BURST_INCR,  0,  1,   3, 32'h0000_4008, AXI_RESP_OKAY});
        vecs.push_back('{0, 32'h0000_5003,   2, 3'd0, AXI_BURST_FIXED, 0, -1,   3, 32'h0000_5000, AXI_RESP_OKAY});
        vecs.push_back('{0, 32'h0000_6000,   3, 3'd1, AXI_BURST_WRAP,  1, -1,   4, 32'h0000_6004, AXI_RESP_OKAY});
        vecs.push_back('{0, 32'h0000_7000,   1, 3'd5, AXI_BURST_INCR,  0, -1,   4, 32'h0000_700C, AXI_RESP_OKAY});
        vecs.push_back('{1, 32'h0000_8004,   0, 3'd3, AXI_BURST_INCR,  0,  1,   2, 32'h0000_8008, AXI_RESP_SLVERR});
        vecs.push_back('{0, 32'h0000_9000, 255, 3'd2, AXI_BURST_INCR,  0, -1, 256, 32'h0000_93FC, AXI_RESP_OKAY});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_psel", apbi.pselx, 0);
        chk("reset_r_valid", xslvo.r_valid, 0);
        chk("reset_b_valid", xslvo.b_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_ar_ready", xslvo.ar_ready, 1);
        chk("idle_aw_ready", xslvo.aw_ready, 1);
        chk("idle_w_ready", xslvo.w_ready, 0);
        cyc();

        tie_test(3);

        poke(32'h0000_1004, 32'hA5A5_0001);
        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                    5'(i + 3), vecs[i].waits, vecs[i].err, 0);
            chk("vec_napb", apb_log.size(), vecs[i].exp_napb);
            if (apb_log.size() > 0) chk("vec_last_paddr", apb_log[apb_log.size() - 1].addr, vecs[i].exp_last_paddr);
            if (vecs[i].wr) chk("vec_bresp", got_bresp, vecs[i].exp_resp);
            else if (got_resp.size() > 0) chk("vec_rresp", got_resp[got_resp.size() - 1], vecs[i].exp_resp);
            if (i == 0 && got_data.size() > 0) chk("vec_rdata_dup", got_data[0], 64'hA5A50001_A5A50001);
            if (i == 3 && got_resp.size() > 1) chk("vec_read_mid_err", got_resp[1], AXI_RESP_SLVERR);
        end

        run_txn(0, 32'h0000_D000, 1, 3'd2, AXI_BURST_INCR, 5'd7, 1, -1, 5);

        // Reset in the middle of a slow APB access.
        apb_wait = 20;
        err_xfer.delete();
        set_req(0, 32'h0000_C000, 0, 3'd2, AXI_BURST_INCR, 5'd4);
        xslvi.ar_valid = 1'b1;
        wait_for(0, "ar_ready_abort");
        cyc();
        xslvi.ar_valid = 1'b0;
        wait_for(5, "penable_abort");
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_psel", apbi.pselx, 0);
        chk("abort_penable", apbi.penable, 0);
        chk("abort_r_valid", xslvo.r_valid, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("release_ar_ready", xslvo.ar_ready, 1);
        chk("release_aw_ready", xslvo.aw_ready, 1);
        chk("release_psel", apbi.pselx, 0);
        apb_wait = 0;
        cyc();
        cyc();
        chk("no_stale_r_valid", xslvo.r_valid, 0);
        tie_test(1);
        run_txn(0, 32'h0000_C000, 0, 3'd2, AXI_BURST_INCR, 5'd9, 0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            bit          wr;
            int          len, sz, nx, err;
            logic [2:0]  size;
            wr   = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            size = 3'($urandom_range(0, 7));
            sz   = (size > 3) ? 3 : int'(size);
            nx   = (len + 1) * ((sz == 3) ? 2 : 1);
            err  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nx - 1) : -1;
            run_txn(wr, $urandom, len, size, 2'($urandom_range(0, 2)), 5'($urandom),
                    $urandom_range(0, 3), err, $urandom_range(0, 2));
        end

        chk("apb_protocol", proto_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
